// File: rtl/issueint.sv
// issueint: integer issue/execute stage. Accepts one ready queue entry per
// cycle, computes a single-cycle 32-bit ALU result, buffers up to two
// results and broadcasts them on the CDB in acceptance order when granted.
module issueint (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  equeueint_opcode,
  input  logic [5:0]  equeueint_rdtag,
  input  logic [31:0] equeueint_rsdata,
  input  logic [31:0] equeueint_rtdata,
  input  logic        equeueint_ready,
  output logic        equeueint_done,
  output logic        cdb_req,
  input  logic        cdb_grant,
  output logic        cdb_valid,
  output logic [5:0]  cdb_tag,
  output logic [31:0] cdb_data
);

  localparam int unsigned TAG_W  = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_NOR  = 3'd5,
    OP_SLT  = 3'd6,
    OP_SLTU = 3'd7
  } op_e;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             rbuf [DEPTH];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [DATA_W-1:0]  alu;
  logic               pop;
  logic               accept;

  // Single-cycle ALU on the queue head operands
  always_comb begin
    alu = '0;
    case (op_e'(equeueint_opcode))
      OP_ADD:  alu = equeueint_rsdata + equeueint_rtdata;
      OP_SUB:  alu = equeueint_rsdata - equeueint_rtdata;
      OP_AND:  alu = equeueint_rsdata & equeueint_rtdata;
      OP_OR:   alu = equeueint_rsdata | equeueint_rtdata;
      OP_XOR:  alu = equeueint_rsdata ^ equeueint_rtdata;
      OP_NOR:  alu = ~(equeueint_rsdata | equeueint_rtdata);
      OP_SLT:  alu = DATA_W'($signed(equeueint_rsdata) < $signed(equeueint_rtdata));
      OP_SLTU: alu = DATA_W'(equeueint_rsdata < equeueint_rtdata);
      default: alu = '0;
    endcase
  end

  // Handshake: a grant frees a slot on the same edge, so a full buffer can still accept
  always_comb begin
    pop            = cdb_grant && (count != '0);
    accept         = equeueint_ready && ((count < CNT_W'(DEPTH)) || pop) && !reset;
    equeueint_done = accept;
    cdb_req        = (count != '0);
  end

  // Result storage; accept is already blocked during reset
  always_ff @(posedge clk) begin
    if (accept) begin
      rbuf[wr_ptr] <= '{tag: equeueint_rdtag, data: alu};
    end
  end

  // Pointers, occupancy and registered CDB broadcast
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr    <= ~rd_ptr;
        cdb_valid <= 1'b1;
        cdb_tag   <= rbuf[rd_ptr].tag;
        cdb_data  <= rbuf[rd_ptr].data;
      end else begin
        cdb_valid <= 1'b0;
      end
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
